// File: rtl/nios2_c_tcm_ram.sv
// nios2_c_tcm_ram: single-port tightly coupled RAM with byte-lane writes,
// a 1- or 2-cycle read pipeline, a word-by-word clear engine and an optional
// per-byte even-parity store (enabled by defining NIOS2_C_TCM_PARITY_EN).
//
// Clear FSM
//   state | meaning
//   IDLE  | normal traffic, commands accepted
//   CLEAR | zeroing one word per enabled cycle, address 0 upward; bus stalled
module nios2_c_tcm_ram #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int DEPTH          = 5000,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    clear_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_busy,
  output logic                    parity_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;

  logic                    en;
  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    in_range;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_err;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    s1_vld, s2_vld;
  logic [DATA_WIDTH-1:0]   s1_data, s2_data;
  logic                    s1_err, s2_err;
  logic                    out_vld, out_err;

  // clken low and reset_req high both freeze the whole block
  assign en          = clken & ~reset_req;
  assign init_busy   = (state_q == CLEAR);
  assign waitrequest = init_busy | ~clken | reset_req;
  assign accept      = chipselect & (read | write) & ~waitrequest;
  // simultaneous read and write is a write only
  assign wr_acc      = accept & write;
  assign rd_acc      = accept & read & ~write;
  assign in_range    = (32'(address) < 32'(DEPTH));

  // Out-of-range reads return zero rather than aliasing into the array
  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[address];
  end

  // Storage: clear engine and bus writes never coincide because the bus is stalled in CLEAR
  always_ff @(posedge clk) begin
    if (en) begin
      if (state_q == CLEAR) begin
        mem[clr_addr_q] <= '0;
      end else if (wr_acc && in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (byteenable[b]) mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

`ifdef NIOS2_C_TCM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  // Parity store: even parity per byte, written alongside its byte; zero word has zero parity
  always_ff @(posedge clk) begin
    if (en) begin
      if (state_q == CLEAR) begin
        par_mem[clr_addr_q] <= '0;
      end else if (wr_acc && in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (byteenable[b]) par_mem[address][b] <= ^writedata[b*8 +: 8];
        end
      end
    end
  end

  // Parity check on the word being read; out-of-range reads never flag
  always_comb begin
    rd_err = 1'b0;
    if (in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (par_mem[address][b] != ^rd_word[b*8 +: 8]) rd_err = 1'b1;
      end
    end
  end
`else
  assign rd_err = 1'b0;
`endif

  // Read pipeline: data captured at acceptance so in-flight reads keep pre-clear data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_err  <= 1'b0;
      s2_vld  <= 1'b0;
      s2_data <= '0;
      s2_err  <= 1'b0;
    end else if (en) begin
      s1_vld <= rd_acc;
      if (rd_acc) begin
        s1_data <= rd_word;
        s1_err  <= rd_err;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_data <= s1_data;
        s2_err  <= s1_err;
      end
    end
  end

  assign out_vld       = (READ_LATENCY == 2) ? s2_vld  : s1_vld;
  assign out_err       = (READ_LATENCY == 2) ? s2_err  : s1_err;
  assign readdata      = (READ_LATENCY == 2) ? s2_data : s1_data;
  // A pending result is held back while frozen and shows for one enabled cycle
  assign readdatavalid = out_vld & en;
  assign parity_err    = out_err & readdatavalid;

  // Clear FSM state register; reset parks in CLEAR at word 0 when auto-clear is on
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Clear FSM next state; clear_req is only observed in IDLE
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
          end
        end
        CLEAR: begin
          if (clr_addr_q == LAST_ADDR) begin
            state_d    = IDLE;
            clr_addr_d = '0;
          end else begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_c_tcm_ram.sv
// Directed bench for nios2_c_tcm_ram: one default instance (latency 1) and
// one latency-2 instance driven by the same inputs.
module tb_nios2_c_tcm_ram;

  logic        clk;
  logic        reset_n;
  logic [12:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic        reset_req;
  logic        clear_req;

  logic [31:0] readdata, readdata2;
  logic        readdatavalid, readdatavalid2;
  logic        waitrequest, waitrequest2;
  logic        init_busy, init_busy2;
  logic        parity_err, parity_err2;

  int n_assert = 0;
  int n_fail   = 0;

  nios2_c_tcm_ram u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .clear_req(clear_req),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .init_busy(init_busy), .parity_err(parity_err)
  );

  nios2_c_tcm_ram #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .clear_req(clear_req),
    .readdata(readdata2), .readdatavalid(readdatavalid2), .waitrequest(waitrequest2),
    .init_busy(init_busy2), .parity_err(parity_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    chipselect = 1'b1;
    write      = 1'b1;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic do_read(input logic [12:0] a, input logic [31:0] exp, input string tag);
    address    = a;
    chipselect = 1'b1;
    read       = 1'b1;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    chk({tag, "_vld"}, readdatavalid, 1);
    chk(tag, readdata, exp);
    chk({tag, "_perr"}, parity_err, 0);
  endtask

  // Counts enabled cycles until init_busy drops, bounded
  task automatic wait_clear(input string tag, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 6000) begin
      tick();
      cnt++;
    end
    chk(tag, cnt, exp_cycles);
  endtask

  initial begin
    int cnt;
    reset_n    = 1'b0;
    address    = '0;
    byteenable = '0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    clken      = 1'b1;
    reset_req  = 1'b0;
    clear_req  = 1'b0;
    repeat (3) tick();

    chk("rst_readdata", readdata, 0);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_busy", init_busy, 1);
    chk("rst_wait", waitrequest, 1);

    // Release, let the clear reach word 100, then abort with reset
    reset_n = 1'b1;
    repeat (100) tick();
    chk("midclr_busy", init_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", init_busy, 1);
    chk("abort_rdv", readdatavalid, 0);
    tick();
    reset_n = 1'b1;

    // Restarted clear must take the full 5000 cycles; clear_req mid-way ignored
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 6000) begin
      clear_req = (cnt == 2000);
      tick();
      cnt++;
    end
    clear_req = 1'b0;
    chk("restart_clear_len", cnt, 5000);
    chk("idle_wait", waitrequest, 0);
    chk("idle_busy", init_busy, 0);

    // Byte-lane writes then immediate read-after-write
    do_write(13'h010, 32'hAABBCCDD, 4'hF);
    do_write(13'h010, 32'h11223344, 4'b0101);
    do_read(13'h010, 32'hAA22CC44, "byte_lanes");

    // Read and write together: write only, no data pulse
    address    = 13'h020;
    writedata  = 32'hDEADBEEF;
    byteenable = 4'hF;
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b1;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    chk("rw_no_rdv", readdatavalid, 0);
    do_read(13'h020, 32'hDEADBEEF, "rw_wrote");

    // Back-to-back reads through both pipelines
    do_write(13'd1, 32'h00000101, 4'hF);
    do_write(13'd2, 32'h00000202, 4'hF);
    do_write(13'd3, 32'h00000303, 4'hF);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = 13'd1;
    tick();
    chk("b2b_l1_r1", readdata, 32'h101);
    chk("b2b_l1_v1", readdatavalid, 1);
    chk("b2b_l2_c1", readdatavalid2, 0);
    address = 13'd2;
    tick();
    chk("b2b_l1_r2", readdata, 32'h202);
    chk("b2b_l2_v2", readdatavalid2, 1);
    chk("b2b_l2_r1", readdata2, 32'h101);
    address = 13'd3;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    chk("b2b_l1_r3", readdata, 32'h303);
    chk("b2b_l2_v3", readdatavalid2, 1);
    chk("b2b_l2_r2", readdata2, 32'h202);
    tick();
    chk("b2b_l1_end", readdatavalid, 0);
    chk("b2b_l2_v4", readdatavalid2, 1);
    chk("b2b_l2_r3", readdata2, 32'h303);
    tick();
    chk("b2b_l2_end", readdatavalid2, 0);

    // Freeze with clken low for three cycles mid-pipeline
    address    = 13'd2;
    chipselect = 1'b1;
    read       = 1'b1;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    clken      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_rdv", readdatavalid, 0);
      chk("frz_rdv2", readdatavalid2, 0);
      chk("frz_wait", waitrequest, 1);
      tick();
    end
    clken = 1'b1;
    #1;
    chk("thaw_rdv", readdatavalid, 1);
    chk("thaw_data", readdata, 32'h202);
    chk("thaw_rdv2_early", readdatavalid2, 0);
    tick();
    chk("thaw_rdv_once", readdatavalid, 0);
    chk("thaw_rdv2", readdatavalid2, 1);
    chk("thaw_data2", readdata2, 32'h202);
    tick();

    // reset_req stalls the bus: this write must not land
    reset_req = 1'b1;
    #1;
    chk("rreq_wait", waitrequest, 1);
    address    = 13'd3;
    writedata  = 32'hFFFFFFFF;
    byteenable = 4'hF;
    chipselect = 1'b1;
    write      = 1'b1;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    reset_req  = 1'b0;
    do_read(13'd3, 32'h00000303, "rreq_nowrite");

    // Out-of-range write discarded, read returns zero with a normal pulse
    do_write(13'd5000, 32'hCAFEF00D, 4'hF);
    do_read(13'd5000, 32'h0, "oor_read");

    // Last word: nonzero, then cleared by clear_req while a read is in flight
    do_write(13'd4999, 32'h12345678, 4'hF);
    do_read(13'd4999, 32'h12345678, "last_word");
    address    = 13'h010;
    chipselect = 1'b1;
    read       = 1'b1;
    clear_req  = 1'b1;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
    clear_req  = 1'b0;
    chk("inflight_rdv", readdatavalid, 1);
    chk("inflight_data", readdata, 32'hAA22CC44);
    chk("clr_busy", init_busy, 1);
    chk("clr_wait", waitrequest, 1);
    tick();
    chk("inflight_rdv2", readdatavalid2, 1);
    chk("inflight_data2", readdata2, 32'hAA22CC44);
    // one of the 5000 clear cycles has already elapsed
    wait_clear("clear_req_len", 4999);
    do_read(13'd4999, 32'h0, "cleared_last");
    do_read(13'h010, 32'h0, "cleared_010");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
